// File: rtl/alu_4_bit_op_seq.sv
// alu_4_bit_op_seq: registered request/response sequencer around a 4-bit ALU,
// with sticky add/sub overflow/carry status and a completed-operation counter.

// Combinational 4-bit ALU: 0=AND, 1=OR, 2=add/sub, 3=set-less-than.
module alu_4_bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       AINV,
    input  logic       BNEG,
    input  logic [1:0] Opr,
    output logic [3:0] RESULT,
    output logic       OVERFLOW,
    output logic       ZERO,
    output logic       COUT
);
    logic [3:0] a_eff;
    logic [3:0] b_eff;
    logic [4:0] sum;

    // Operand conditioning, adder and result mux
    always_comb begin
        a_eff    = AINV ? ~A : A;
        b_eff    = BNEG ? ~B : B;
        sum      = {1'b0, a_eff} + {1'b0, b_eff} + 5'(BNEG);
        OVERFLOW = (a_eff[3] == b_eff[3]) && (sum[3] != a_eff[3]);
        COUT     = sum[4];
        case (Opr)
            2'd0:    RESULT = a_eff & b_eff;
            2'd1:    RESULT = a_eff | b_eff;
            2'd2:    RESULT = sum[3:0];
            default: RESULT = {3'b000, sum[3] ^ OVERFLOW};
        endcase
        ZERO = (RESULT == 4'd0);
    end
endmodule

module alu_4_bit_op_seq (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [3:0] IN_A,
    input  logic [3:0] IN_B,
    input  logic       IN_AINV,
    input  logic       IN_BNEG,
    input  logic [1:0] IN_OPR,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [3:0] OUT_RESULT,
    output logic       OUT_OVERFLOW,
    output logic       OUT_ZERO,
    output logic       OUT_COUT,
    input  logic       CLR_STICKY,
    output logic       STICKY_OVF,
    output logic       STICKY_COUT,
    output logic [7:0] OP_COUNT
);
    localparam int unsigned DATA_W = 4;
    localparam int unsigned OPR_W  = 2;
    localparam int unsigned CNT_W  = 8;
    localparam logic [OPR_W-1:0] OPR_ADDSUB = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q,       state_d;
    logic [DATA_W-1:0]   a_q,           a_d;
    logic [DATA_W-1:0]   b_q,           b_d;
    logic                ainv_q,        ainv_d;
    logic                bneg_q,        bneg_d;
    logic [OPR_W-1:0]    opr_q,         opr_d;
    logic [DATA_W-1:0]   result_q,      result_d;
    logic                ovf_q,         ovf_d;
    logic                zero_q,        zero_d;
    logic                cout_q,        cout_d;
    logic                sticky_ovf_q,  sticky_ovf_d;
    logic                sticky_cout_q, sticky_cout_d;
    logic [CNT_W-1:0]    count_q,       count_d;
    logic                in_ready_q,    in_ready_d;
    logic                out_valid_q,   out_valid_d;

    logic [DATA_W-1:0]   alu_result;
    logic                alu_ovf;
    logic                alu_zero;
    logic                alu_cout;
    logic                ovf_gated;
    logic                cout_gated;

    // ALU driven straight from the operand registers
    alu_4_bit u_alu (
        .A        (a_q),
        .B        (b_q),
        .AINV     (ainv_q),
        .BNEG     (bneg_q),
        .Opr      (opr_q),
        .RESULT   (alu_result),
        .OVERFLOW (alu_ovf),
        .ZERO     (alu_zero),
        .COUT     (alu_cout)
    );

    // Next-state, capture, sticky and counter logic
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        ainv_d        = ainv_q;
        bneg_d        = bneg_q;
        opr_d         = opr_q;
        result_d      = result_q;
        ovf_d         = ovf_q;
        zero_d        = zero_q;
        cout_d        = cout_q;
        sticky_ovf_d  = sticky_ovf_q;
        sticky_cout_d = sticky_cout_q;
        count_d       = count_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;

        // Overflow/carry only mean something for add/subtract
        ovf_gated  = (opr_q == OPR_ADDSUB) && alu_ovf;
        cout_gated = (opr_q == OPR_ADDSUB) && alu_cout;

        // Clear first so a same-cycle set below takes priority
        if (CLR_STICKY) begin
            sticky_ovf_d  = 1'b0;
            sticky_cout_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d        = IN_A;
                    b_d        = IN_B;
                    ainv_d     = IN_AINV;
                    bneg_d     = IN_BNEG;
                    opr_d      = IN_OPR;
                    in_ready_d = 1'b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                result_d    = alu_result;
                ovf_d       = ovf_gated;
                zero_d      = alu_zero;
                cout_d      = cout_gated;
                if (ovf_gated) begin
                    sticky_ovf_d = 1'b1;
                end
                if (cout_gated) begin
                    sticky_cout_d = 1'b1;
                end
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (OUT_READY) begin
                    count_d     = count_q + 8'd1;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            ainv_q        <= 1'b0;
            bneg_q        <= 1'b0;
            opr_q         <= '0;
            result_q      <= '0;
            ovf_q         <= 1'b0;
            zero_q        <= 1'b0;
            cout_q        <= 1'b0;
            sticky_ovf_q  <= 1'b0;
            sticky_cout_q <= 1'b0;
            count_q       <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            ainv_q        <= ainv_d;
            bneg_q        <= bneg_d;
            opr_q         <= opr_d;
            result_q      <= result_d;
            ovf_q         <= ovf_d;
            zero_q        <= zero_d;
            cout_q        <= cout_d;
            sticky_ovf_q  <= sticky_ovf_d;
            sticky_cout_q <= sticky_cout_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign IN_READY     = in_ready_q;
    assign OUT_VALID    = out_valid_q;
    assign OUT_RESULT   = result_q;
    assign OUT_OVERFLOW = ovf_q;
    assign OUT_ZERO     = zero_q;
    assign OUT_COUT     = cout_q;
    assign STICKY_OVF   = sticky_ovf_q;
    assign STICKY_COUT  = sticky_cout_q;
    assign OP_COUNT     = count_q;
endmodule

// File: tb/tb_alu_4_bit_op_seq.sv
// Bench for alu_4_bit_op_seq: directed literal checks plus randomized ops,
// with an arithmetic reference model compared against the outputs every cycle.
module tb_alu_4_bit_op_seq;
    logic       CLK;
    logic       RESET;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] IN_A;
    logic [3:0] IN_B;
    logic       IN_AINV;
    logic       IN_BNEG;
    logic [1:0] IN_OPR;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [3:0] OUT_RESULT;
    logic       OUT_OVERFLOW;
    logic       OUT_ZERO;
    logic       OUT_COUT;
    logic       CLR_STICKY;
    logic       STICKY_OVF;
    logic       STICKY_COUT;
    logic [7:0] OP_COUNT;

    int total = 0;
    int bad   = 0;

    alu_4_bit_op_seq dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_A         (IN_A),
        .IN_B         (IN_B),
        .IN_AINV      (IN_AINV),
        .IN_BNEG      (IN_BNEG),
        .IN_OPR       (IN_OPR),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .OUT_RESULT   (OUT_RESULT),
        .OUT_OVERFLOW (OUT_OVERFLOW),
        .OUT_ZERO     (OUT_ZERO),
        .OUT_COUT     (OUT_COUT),
        .CLR_STICKY   (CLR_STICKY),
        .STICKY_OVF   (STICKY_OVF),
        .STICKY_COUT  (STICKY_COUT),
        .OP_COUNT     (OP_COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- reference model ----------------
    // ALU arithmetic on plain integers: two's complement via true signed sums.
    function automatic void alu_ref(input int a, input int b, input int ainv, input int bneg,
                                    input int opr, output int r, output int ov, output int co);
        int ae, be, s, sa, sb, ss;
        ae = (ainv != 0) ? 15 - a : a;
        be = (bneg != 0) ? 15 - b : b;
        s  = ae + be + bneg;
        co = (s > 15) ? 1 : 0;
        sa = (ae > 7) ? ae - 16 : ae;
        sb = (be > 7) ? be - 16 : be;
        ss = sa + sb + bneg;
        ov = (ss > 7 || ss < -8) ? 1 : 0;
        case (opr)
            0:       r = ae & be;
            1:       r = ae | be;
            2:       r = s % 16;
            default: r = (ss < 0) ? 1 : 0;
        endcase
    endfunction

    int m_init = 0;
    int m_phase, m_a, m_b, m_ai, m_bn, m_opr;
    int m_res, m_ov, m_z, m_co, m_sov, m_sco, m_cnt;

    // Cycle-level model: waiting -> computing -> presenting
    always @(posedge CLK) begin
        int r, ov, co;
        if (RESET) begin
            m_init = 1; m_phase = 0;
            m_a = 0; m_b = 0; m_ai = 0; m_bn = 0; m_opr = 0;
            m_res = 0; m_ov = 0; m_z = 0; m_co = 0; m_sov = 0; m_sco = 0; m_cnt = 0;
        end else if (m_init != 0) begin
            if (CLR_STICKY) begin
                m_sov = 0;
                m_sco = 0;
            end
            if (m_phase == 0) begin
                if (IN_VALID) begin
                    m_a = int'(IN_A); m_b = int'(IN_B); m_ai = int'(IN_AINV);
                    m_bn = int'(IN_BNEG); m_opr = int'(IN_OPR);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                alu_ref(m_a, m_b, m_ai, m_bn, m_opr, r, ov, co);
                if (m_opr != 2) begin
                    ov = 0;
                    co = 0;
                end
                m_res = r; m_ov = ov; m_co = co; m_z = (r == 0) ? 1 : 0;
                if (ov != 0) m_sov = 1;
                if (co != 0) m_sco = 1;
                m_phase = 2;
            end else begin
                if (OUT_READY) begin
                    m_cnt = (m_cnt + 1) % 256;
                    m_phase = 0;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge CLK) begin
        logic [19:0] act, exp;
        if (m_init != 0) begin
            act = {IN_READY, OUT_VALID, OUT_RESULT, OUT_OVERFLOW, OUT_ZERO, OUT_COUT,
                   STICKY_OVF, STICKY_COUT, OP_COUNT};
            exp = {(m_phase == 0), (m_phase == 2), 4'(m_res), (m_ov != 0), (m_z != 0),
                   (m_co != 0), (m_sov != 0), (m_sco != 0), 8'(m_cnt)};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model t=%0t: got %h want %h", $time, act, exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 10 && IN_READY !== 1'b1; i++) tick();
        chk("wait_in_ready", 8'(IN_READY), 8'd1);
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ai,
                         input logic bn, input logic [1:0] opr);
        IN_VALID = 1'b1; IN_A = a; IN_B = b; IN_AINV = ai; IN_BNEG = bn; IN_OPR = opr;
    endtask

    // One full transaction; returns the outputs seen while OUT_VALID is high
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic ai,
                          input logic bn, input logic [1:0] opr, input int hold,
                          input logic clr_cap, output logic [3:0] r, output logic ov,
                          output logic z, output logic co);
        wait_ready();
        drive(a, b, ai, bn, opr);
        tick();
        IN_VALID = 1'b0;
        chk("exec_out_valid", 8'(OUT_VALID), 8'd0);
        chk("exec_in_ready", 8'(IN_READY), 8'd0);
        CLR_STICKY = clr_cap;
        tick();
        CLR_STICKY = 1'b0;
        chk("hold_out_valid", 8'(OUT_VALID), 8'd1);
        r = OUT_RESULT; ov = OUT_OVERFLOW; z = OUT_ZERO; co = OUT_COUT;
        repeat (hold) tick();
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    task automatic chk_flags(input string name, input logic [3:0] r, input logic ov,
                             input logic z, input logic co, input logic [6:0] exp);
        chk(name, {1'b0, r, ov, z, co}, {1'b0, exp});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0] r;
        logic ov, z, co;
        RESET = 1'b1; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; IN_AINV = 1'b0;
        IN_BNEG = 1'b0; IN_OPR = '0; OUT_READY = 1'b0; CLR_STICKY = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        chk("reset_in_ready", 8'(IN_READY), 8'd1);
        chk("reset_out_valid", 8'(OUT_VALID), 8'd0);
        chk("reset_count", OP_COUNT, 8'd0);

        // ADD 3+4 -> 0111, no flags
        run_op(4'd3, 4'd4, 1'b0, 1'b0, 2'd2, 0, 1'b0, r, ov, z, co);
        chk_flags("add_3_4", r, ov, z, co, {4'b0111, 1'b0, 1'b0, 1'b0});
        chk("count_after_first", OP_COUNT, 8'd1);

        // ADD 4+5 -> 1001 signed overflow
        run_op(4'd4, 4'd5, 1'b0, 1'b0, 2'd2, 1, 1'b0, r, ov, z, co);
        chk_flags("add_4_5", r, ov, z, co, {4'b1001, 1'b1, 1'b0, 1'b0});
        chk("sticky_ovf_set", {6'd0, STICKY_OVF, STICKY_COUT}, 8'b10);

        // ADD 9+8 -> 0001 overflow and carry
        run_op(4'd9, 4'd8, 1'b0, 1'b0, 2'd2, 0, 1'b0, r, ov, z, co);
        chk_flags("add_9_8", r, ov, z, co, {4'b0001, 1'b1, 1'b0, 1'b1});
        chk("sticky_both_set", {6'd0, STICKY_OVF, STICKY_COUT}, 8'b11);

        // Clear coinciding with an overflowing capture: set wins
        run_op(4'd9, 4'd8, 1'b0, 1'b0, 2'd2, 0, 1'b1, r, ov, z, co);
        chk("sticky_set_wins", {6'd0, STICKY_OVF, STICKY_COUT}, 8'b11);

        // Clear alone
        CLR_STICKY = 1'b1;
        tick();
        CLR_STICKY = 1'b0;
        chk("sticky_cleared", {6'd0, STICKY_OVF, STICKY_COUT}, 8'b00);

        // Subtraction and zero
        run_op(4'd4, 4'd5, 1'b0, 1'b1, 2'd2, 0, 1'b0, r, ov, z, co);
        chk_flags("sub_4_5", r, ov, z, co, {4'b1111, 1'b0, 1'b0, 1'b0});
        run_op(4'd4, 4'd4, 1'b0, 1'b1, 2'd2, 2, 1'b0, r, ov, z, co);
        chk_flags("sub_4_4", r, ov, z, co, {4'b0000, 1'b0, 1'b1, 1'b1});
        run_op(4'd11, 4'd7, 1'b0, 1'b1, 2'd2, 0, 1'b0, r, ov, z, co);
        chk_flags("sub_m5_7", r, ov, z, co, {4'b0100, 1'b1, 1'b0, 1'b1});

        // Backpressure: hold 5 cycles with a pending request on the input
        wait_ready();
        drive(4'd2, 4'd3, 1'b0, 1'b0, 2'd2);
        tick();
        IN_VALID = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'd1, 4'd1, 1'b0, 1'b0, 2'd2);
            chk("bp_stable", {OUT_VALID, IN_READY, 2'b00, OUT_RESULT}, 8'b1000_0101);
            tick();
        end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk("bp_release", {6'd0, IN_READY, OUT_VALID}, 8'b10);
        tick();
        IN_VALID = 1'b0;
        chk("bp_accepted", 8'(IN_READY), 8'd0);
        tick();
        chk("bp_pending_result", {OUT_VALID, 3'b000, OUT_RESULT}, 8'b1000_0010);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        // Reset while in EXEC (sticky and count are nonzero beforehand)
        wait_ready();
        drive(4'd9, 4'd8, 1'b0, 1'b0, 2'd2);
        tick();
        IN_VALID = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst_exec_outs", {OUT_VALID, OUT_RESULT, OUT_OVERFLOW, OUT_ZERO, OUT_COUT}, 8'd0);
        chk("rst_exec_status", {5'd0, IN_READY, STICKY_OVF, STICKY_COUT}, 8'b100);
        chk("rst_exec_count", OP_COUNT, 8'd0);

        // Reset while in HOLD
        drive(4'd9, 4'd8, 1'b0, 1'b0, 2'd2);
        tick();
        IN_VALID = 1'b0;
        tick();
        chk("pre_rst_hold", {OUT_VALID, STICKY_OVF, STICKY_COUT, 1'b0, OUT_RESULT}, 8'b1110_0001);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst_hold_outs", {OUT_VALID, OUT_RESULT, OUT_OVERFLOW, OUT_ZERO, OUT_COUT}, 8'd0);
        chk("rst_hold_status", {5'd0, IN_READY, STICKY_OVF, STICKY_COUT}, 8'b100);
        chk("rst_hold_count", OP_COUNT, 8'd0);

        // Opr=0 with carrying operands: flags gated off
        run_op(4'd15, 4'd15, 1'b0, 1'b0, 2'd0, 0, 1'b0, r, ov, z, co);
        chk_flags("and_gated", r, ov, z, co, {4'b1111, 1'b0, 1'b0, 1'b0});

        // 255 more randomized ops complete 256 since reset
        for (int i = 0; i < 255; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 3) == 0), r, ov, z, co);
        end
        chk("count_wrap", OP_COUNT, 8'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
